// File: rtl/cpu_step_ctrl_if.sv
// Signal bundle between the RP2040-facing io pins and the CPU step controller.
// The master side drives the raw io lines; the slave side (the controller)
// returns the conditioned step pulse and the values captured with it.
interface cpu_step_ctrl_if;
  logic [3:0] i_data_raw;
  logic [1:0] i_instr_raw;
  logic       i_step_raw;
  logic       i_auto_raw;
  logic       o_step;
  logic [1:0] o_instruction;
  logic [3:0] o_data;
  logic       o_data_3_latched;
  logic [7:0] o_step_count;

  modport master (
    output i_data_raw, i_instr_raw, i_step_raw, i_auto_raw,
    input  o_step, o_instruction, o_data, o_data_3_latched, o_step_count
  );

  modport slave (
    input  i_data_raw, i_instr_raw, i_step_raw, i_auto_raw,
    output o_step, o_instruction, o_data, o_data_3_latched, o_step_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Input-conditioning stage in front of the 4-bit CPU core.
// Raw RP2040 lines are synchronised, the manual step strobe is debounced and
// edge-detected, and an optional auto-run prescaler generates RUNPROG steps.
// Each step pulse captures the mode and data nibble so the core sees them
// stable alongside the pulse.
//
// Operating modes (no explicit state register; selected from synced inputs):
//   mode   | meaning
//   manual | auto_s==0 or instr_s!=11: rising debounced step edge -> one pulse
//   auto   | auto_s==1 and instr_s==11: prescaler terminal count -> one pulse
module cpu_step_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int AUTO_DIV    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_step_ctrl_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PS_W = $clog2(AUTO_DIV);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE - 1);
  localparam logic [PS_W-1:0] PS_LOAD = PS_W'(AUTO_DIV - 1);

  logic [7:0] raw_vec;
  logic [7:0] sync_q [SYNC_STAGES];

  logic [3:0] data_s;
  logic [1:0] instr_s;
  logic       step_s;
  logic       auto_s;

  logic            step_db;
  logic [DB_W-1:0] db_cnt;
  logic            db_cur;
  logic            db_prev;
  logic [PS_W-1:0] ps_cnt;

  logic auto_active;
  logic manual_rise;
  logic auto_fire;
  logic step_fire;

  assign raw_vec = {bus.i_auto_raw, bus.i_step_raw, bus.i_instr_raw, bus.i_data_raw};

  assign data_s  = sync_q[SYNC_STAGES-1][3:0];
  assign instr_s = sync_q[SYNC_STAGES-1][5:4];
  assign step_s  = sync_q[SYNC_STAGES-1][6];
  assign auto_s  = sync_q[SYNC_STAGES-1][7];

  assign auto_active = auto_s && (instr_s == 2'b11);
  assign manual_rise = db_cur && !db_prev;
  assign auto_fire   = auto_active && (ps_cnt == '0);
  // The o_step guard keeps a mode switch from ever producing adjacent pulses.
  assign step_fire   = (auto_active ? auto_fire : manual_rise) && !bus.o_step;

  // Multi-flop synchroniser on every raw io bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_vec;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Debounce: down-counter of remaining stable cycles before step_db follows step_s.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_db <= 1'b0;
      db_cnt  <= DB_LOAD;
    end else if (step_s == step_db) begin
      db_cnt <= DB_LOAD;
    end else if (db_cnt == '0) begin
      step_db <= step_s;
      db_cnt  <= DB_LOAD;
    end else begin
      db_cnt <= db_cnt - 1'b1;
    end
  end

  // Registered current/previous copies of the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cur  <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      db_cur  <= step_db;
      db_prev <= db_cur;
    end
  end

  // Auto-run prescaler: down-counter reloaded whenever auto mode is off or at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= PS_LOAD;
    end else if (!auto_active || ps_cnt == '0) begin
      ps_cnt <= PS_LOAD;
    end else begin
      ps_cnt <= ps_cnt - 1'b1;
    end
  end

  // Registered step pulse with mode/data capture and pulse counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.o_step           <= 1'b0;
      bus.o_instruction    <= 2'b00;
      bus.o_data           <= 4'h0;
      bus.o_data_3_latched <= 1'b0;
      bus.o_step_count     <= 8'h00;
    end else begin
      bus.o_step <= step_fire;
      if (step_fire) begin
        bus.o_instruction    <= instr_s;
        bus.o_data           <= data_s;
        bus.o_data_3_latched <= data_s[3];
        bus.o_step_count     <= bus.o_step_count + 8'h01;
      end
    end
  end

endmodule
